mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 59 +++++
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the RV64 memory-access stage: access-size and FSM encodings,
// the execute/write-back bundles and the byte-lane helper functions.
package mem_stage_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } mem_state_e;

   typedef struct packed {
      logic            is_load;
      logic            is_store;
      mem_size_e       size;
      logic            is_unsigned;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [4:0]      rd_addr;
      logic            rd_w_ena;
   } ex_mem_packet_t;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rd_addr;
      logic            rd_w_ena;
      logic [XLEN-1:0] data;
   } mem_wb_packet_t;

   // Address bits that must be zero for a naturally aligned access of this size.
   function automatic logic [2:0] size_low_mask(input mem_size_e size);
      case (size)
         SZ_B:    size_low_mask = 3'b000;
         SZ_H:    size_low_mask = 3'b001;
         SZ_W:    size_low_mask = 3'b011;
         SZ_D:    size_low_mask = 3'b111;
         default: size_low_mask = 3'b111;
      endcase
   endfunction

   function automatic logic [7:0] store_mask(input mem_size_e size, input logic [2:0] off);
      case (size)
         SZ_B:    store_mask = 8'h01 << off;
         SZ_H:    store_mask = 8'h03 << off;
         SZ_W:    store_mask = 8'h0F << off;
         SZ_D:    store_mask = 8'hFF;
         default: store_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: shifts the addressed lanes down, truncates to the
// access size and sign- or zero-extends to 64 bits. Kept standalone for cache reuse.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  off,
   input  mem_size_e   size,
   input  logic        is_unsigned,
   output logic [63:0] data
);

   logic [63:0] shifted;

   assign shifted = rdata >> {off, 3'b000};

   // Truncate to the access size and extend.
   always_comb begin
      data = shifted;
      case (size)
         SZ_B:    data = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         SZ_H:    data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         SZ_W:    data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         SZ_D:    data = shifted;
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: pass-through, loads and stores over a req/gnt/rvalid port.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic                  ex_is_load,
   input  logic                  ex_is_store,
   input  logic [1:0]            ex_size,
   input  logic                  ex_unsigned,
   input  logic [ADDR_WIDTH-1:0] ex_result,
   input  logic [DATA_WIDTH-1:0] ex_wdata,
   input  logic [4:0]            ex_rd_addr,
   input  logic                  ex_rd_w_ena,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [7:0]            dmem_wmask,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  wb_valid,
   output logic [4:0]            wb_rd_addr,
   output logic                  wb_rd_w_ena,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  misalign
);

   ex_mem_packet_t ex_pkt_s;
   mem_wb_packet_t wb_r;
   mem_state_e     state_r;

   logic           is_store_r;
   mem_size_e      size_r;
   logic           uns_r;
   logic [2:0]     off_r;
   logic [4:0]     rd_addr_r;
   logic           rd_w_ena_r;
   logic           dmem_req_r;
   logic           dmem_we_r;
   logic [ADDR_WIDTH-1:0] dmem_addr_r;
   logic [DATA_WIDTH-1:0] dmem_wdata_r;
   logic [7:0]     dmem_wmask_r;
   logic           misalign_r;

   logic           mem_op_s;
   logic           misal_s;
   logic [2:0]     off_s;
   logic [63:0]    load_data_s;

   // Bundle the execute inputs.
   always_comb begin
      ex_pkt_s.is_load     = ex_is_load;
      ex_pkt_s.is_store    = ex_is_store;
      ex_pkt_s.size        = mem_size_e'(ex_size);
      ex_pkt_s.is_unsigned = ex_unsigned;
      ex_pkt_s.addr        = ex_result;
      ex_pkt_s.wdata       = ex_wdata;
      ex_pkt_s.rd_addr     = ex_rd_addr;
      ex_pkt_s.rd_w_ena    = ex_rd_w_ena;
   end

   assign mem_op_s = ex_pkt_s.is_load | ex_pkt_s.is_store;
   assign ex_ready = (state_r == IDLE);

   // Lane offset is aligned down to the access size; misalignment detected only when trapping.
   always_comb begin
      off_s   = ex_pkt_s.addr[2:0] & ~size_low_mask(ex_pkt_s.size);
`ifdef MISALIGN_TRAP_EN
      misal_s = mem_op_s && ((ex_pkt_s.addr[2:0] & size_low_mask(ex_pkt_s.size)) != 3'b000);
`else
      misal_s = 1'b0;
`endif
   end

   load_align u_load_align (
      .rdata       (dmem_rdata),
      .off         (off_r),
      .size        (size_r),
      .is_unsigned (uns_r),
      .data        (load_data_s)
   );

   // Stage FSM with registered memory-port and write-back outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         is_store_r   <= 1'b0;
         size_r       <= SZ_B;
         uns_r        <= 1'b0;
         off_r        <= 3'd0;
         rd_addr_r    <= 5'd0;
         rd_w_ena_r   <= 1'b0;
         dmem_req_r   <= 1'b0;
         dmem_we_r    <= 1'b0;
         dmem_addr_r  <= {ADDR_WIDTH{1'b0}};
         dmem_wdata_r <= {DATA_WIDTH{1'b0}};
         dmem_wmask_r <= 8'h00;
         misalign_r   <= 1'b0;
         wb_r.valid   <= 1'b0;
         wb_r.rd_addr <= 5'd0;
         wb_r.rd_w_ena <= 1'b0;
         wb_r.data    <= 64'd0;
      end else begin
         wb_r.valid <= 1'b0;
         misalign_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (ex_valid) begin
                  if (!mem_op_s) begin
                     wb_r.valid    <= 1'b1;
                     wb_r.rd_addr  <= ex_pkt_s.rd_addr;
                     wb_r.rd_w_ena <= ex_pkt_s.rd_w_ena && (ex_pkt_s.rd_addr != 5'd0);
                     wb_r.data     <= ex_pkt_s.addr;
                  end else if (misal_s) begin
                     wb_r.valid    <= 1'b1;
                     wb_r.rd_addr  <= ex_pkt_s.rd_addr;
                     wb_r.rd_w_ena <= 1'b0;
                     wb_r.data     <= 64'd0;
                     misalign_r    <= 1'b1;
                  end else begin
                     is_store_r   <= ex_pkt_s.is_store;
                     size_r       <= ex_pkt_s.size;
                     uns_r        <= ex_pkt_s.is_unsigned;
                     off_r        <= off_s;
                     rd_addr_r    <= ex_pkt_s.rd_addr;
                     rd_w_ena_r   <= ex_pkt_s.rd_w_ena && (ex_pkt_s.rd_addr != 5'd0);
                     dmem_req_r   <= 1'b1;
                     dmem_we_r    <= ex_pkt_s.is_store;
                     dmem_addr_r  <= {ex_pkt_s.addr[ADDR_WIDTH-1:3], 3'b000};
                     dmem_wmask_r <= store_mask(ex_pkt_s.size, off_s);
                     dmem_wdata_r <= ex_pkt_s.wdata << {off_s, 3'b000};
                     state_r      <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  dmem_req_r <= 1'b0;
                  if (is_store_r) begin
                     wb_r.valid    <= 1'b1;
                     wb_r.rd_addr  <= rd_addr_r;
                     wb_r.rd_w_ena <= 1'b0;
                     wb_r.data     <= 64'd0;
                     state_r       <= IDLE;
                  end else begin
                     state_r <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  wb_r.valid    <= 1'b1;
                  wb_r.rd_addr  <= rd_addr_r;
                  wb_r.rd_w_ena <= rd_w_ena_r;
                  wb_r.data     <= load_data_s;
                  state_r       <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign dmem_req    = dmem_req_r;
   assign dmem_we     = dmem_we_r;
   assign dmem_addr   = dmem_addr_r;
   assign dmem_wdata  = dmem_wdata_r;
   assign dmem_wmask  = dmem_wmask_r;
   assign wb_valid    = wb_r.valid;
   assign wb_rd_addr  = wb_r.rd_addr;
   assign wb_rd_w_ena = wb_r.rd_w_ena;
   assign wb_data     = wb_r.data;
   assign misalign    = misalign_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected write-backs,
// a negedge monitor pops and compares them, including the arrival cycle.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_unsigned, ex_rd_w_ena;
   logic [1:0]  ex_size;
   logic [63:0] ex_result, ex_wdata;
   logic [4:0]  ex_rd_addr;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [7:0]  dmem_wmask;
   logic        wb_valid, wb_rd_w_ena, misalign;
   logic [4:0]  wb_rd_addr;
   logic [63:0] wb_data;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        wena;
      logic        mis;
      logic        chk_data;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   int   cyc_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_size(ex_size), .ex_unsigned(ex_unsigned),
      .ex_result(ex_result), .ex_wdata(ex_wdata),
      .ex_rd_addr(ex_rd_addr), .ex_rd_w_ena(ex_rd_w_ena),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_w_ena(wb_rd_w_ena),
      .wb_data(wb_data), .misalign(misalign)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] d, input logic [4:0] rd, input logic wena,
                       input logic mis, input logic chkd);
      exp_t x;
      x.data = d; x.rd = rd; x.wena = wena; x.mis = mis; x.chk_data = chkd;
      x.cyc = cyc_cnt + 1;
      q.push_back(x);
   endtask

   // Monitor: every write-back must match the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && wb_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: got wb_valid with rd=%0d data=0x%0h, expected none", wb_rd_addr, wb_data);
         end else begin
            e = q.pop_front();
            chk("wb_cycle", 64'(cyc_cnt), 64'(e.cyc));
            chk("wb_rd_addr", {59'd0, wb_rd_addr}, {59'd0, e.rd});
            chk("wb_rd_w_ena", {63'd0, wb_rd_w_ena}, {63'd0, e.wena});
            chk("misalign", {63'd0, misalign}, {63'd0, e.mis});
            if (e.chk_data) chk("wb_data", wb_data, e.data);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] res, input logic [63:0] wd, input logic [4:0] rd);
      ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_size = sz; ex_unsigned = uns;
      ex_result = res; ex_wdata = wd; ex_rd_addr = rd; ex_rd_w_ena = 1'b1;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ex_ready"}, {63'd0, ex_ready}, 64'd1);
      chk({tag, "_dmem_req"}, {63'd0, dmem_req}, 64'd0);
      chk({tag, "_dmem_we"}, {63'd0, dmem_we}, 64'd0);
      chk({tag, "_dmem_addr"}, dmem_addr, 64'd0);
      chk({tag, "_dmem_wdata"}, dmem_wdata, 64'd0);
      chk({tag, "_dmem_wmask"}, {56'd0, dmem_wmask}, 64'd0);
      chk({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
      chk({tag, "_wb_rd_addr"}, {59'd0, wb_rd_addr}, 64'd0);
      chk({tag, "_wb_rd_w_ena"}, {63'd0, wb_rd_w_ena}, 64'd0);
      chk({tag, "_wb_data"}, wb_data, 64'd0);
      chk({tag, "_misalign"}, {63'd0, misalign}, 64'd0);
   endtask

   task automatic do_store(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [4:0] rd, input int gdelay, input logic [63:0] ea,
                           input logic [7:0] em, input logic [63:0] ew);
      chk("st_ex_ready_idle", {63'd0, ex_ready}, 64'd1);
      drive(1'b0, 1'b1, sz, 1'b0, addr, wd, rd);
      tick();
      idle_ex();
      chk("st_we", {63'd0, dmem_we}, 64'd1);
      chk("st_addr", dmem_addr, ea);
      chk("st_wmask", {56'd0, dmem_wmask}, {56'd0, em});
      chk("st_wdata", dmem_wdata, ew);
      chk("st_ex_ready_busy", {63'd0, ex_ready}, 64'd0);
      for (int i = 0; i < gdelay; i++) begin
         chk("st_req_held", {63'd0, dmem_req}, 64'd1);
         chk("st_addr_held", dmem_addr, ea);
         tick();
      end
      chk("st_req", {63'd0, dmem_req}, 64'd1);
      dmem_gnt = 1'b1;
      push(64'd0, rd, 1'b0, 1'b0, 1'b0);
      tick();
      dmem_gnt = 1'b0;
      chk("st_req_drop", {63'd0, dmem_req}, 64'd0);
      chk("st_ex_ready_back", {63'd0, ex_ready}, 64'd1);
   endtask

   task automatic do_load(input logic [1:0] sz, input logic uns, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [4:0] rd, input int gdelay,
                          input int rvdelay, input logic [63:0] ea, input logic [63:0] ed);
      chk("ld_ex_ready_idle", {63'd0, ex_ready}, 64'd1);
      drive(1'b1, 1'b0, sz, uns, addr, 64'd0, rd);
      tick();
      idle_ex();
      chk("ld_we", {63'd0, dmem_we}, 64'd0);
      chk("ld_addr", dmem_addr, ea);
      for (int i = 0; i < gdelay; i++) begin
         chk("ld_req_held", {63'd0, dmem_req}, 64'd1);
         tick();
      end
      chk("ld_req", {63'd0, dmem_req}, 64'd1);
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      chk("ld_req_drop", {63'd0, dmem_req}, 64'd0);
      for (int i = 1; i < rvdelay; i++) begin
         chk("ld_ex_ready_wait", {63'd0, ex_ready}, 64'd0);
         tick();
      end
      chk("ld_ex_ready_wait", {63'd0, ex_ready}, 64'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata = rdata;
      push(ed, rd, (rd != 5'd0), 1'b0, 1'b1);
      tick();
      dmem_rvalid = 1'b0;
      chk("ld_ex_ready_back", {63'd0, ex_ready}, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle_ex();
      ex_size = 2'b00; ex_unsigned = 1'b0; ex_result = 64'd0; ex_wdata = 64'd0;
      ex_rd_addr = 5'd0; ex_rd_w_ena = 1'b0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b1;
      tick();

      // Pass-through, back to back; rd=0 must suppress the write enable.
      chk("pt_ex_ready", {63'd0, ex_ready}, 64'd1);
      drive(1'b0, 1'b0, 2'b11, 1'b0, 64'h1234, 64'd0, 5'd5);
      push(64'h1234, 5'd5, 1'b1, 1'b0, 1'b1);
      tick();
      chk("pt_ex_ready_b2b", {63'd0, ex_ready}, 64'd1);
      drive(1'b0, 1'b0, 2'b11, 1'b0, 64'hDEAD, 64'd0, 5'd0);
      push(64'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
      idle_ex();
      tick();

      // Stores: byte with 3-cycle grant delay, word, double.
      do_store(2'b00, 64'h1003, 64'hAB, 5'd7, 3, 64'h1000, 8'h08, 64'hAB00_0000);
      do_store(2'b10, 64'h7004, 64'hCAFE_BABE, 5'd8, 0, 64'h7000, 8'hF0, 64'hCAFE_BABE_0000_0000);
      do_store(2'b11, 64'h7008, 64'h1122_3344_5566_7788, 5'd9, 1, 64'h7008, 8'hFF, 64'h1122_3344_5566_7788);

      // Loads.
      do_load(2'b01, 1'b0, 64'h2006, 64'h8001_0000_0000_0000, 5'd10, 0, 1, 64'h2000, 64'hFFFF_FFFF_FFFF_8001);
      do_load(2'b01, 1'b1, 64'h2006, 64'h8001_0000_0000_0000, 5'd11, 1, 2, 64'h2000, 64'h8001);
      do_load(2'b10, 1'b0, 64'h4004, 64'h8765_4321_0000_0000, 5'd12, 0, 4, 64'h4000, 64'hFFFF_FFFF_8765_4321);
      // New bundle accepted in the same cycle as the load write-back.
      drive(1'b0, 1'b0, 2'b11, 1'b0, 64'h55, 64'd0, 5'd13);
      push(64'h55, 5'd13, 1'b1, 1'b0, 1'b1);
      tick();
      idle_ex();
      do_load(2'b00, 1'b1, 64'h5001, 64'h0000_0000_0000_F000, 5'd14, 0, 1, 64'h5000, 64'hF0);
      do_load(2'b00, 1'b0, 64'h5001, 64'h0000_0000_0000_F000, 5'd15, 0, 1, 64'h5000, 64'hFFFF_FFFF_FFFF_FFF0);
      do_load(2'b11, 1'b0, 64'h6000, 64'h0123_4567_89AB_CDEF, 5'd0, 2, 3, 64'h6000, 64'h0123_4567_89AB_CDEF);

      // Misaligned word load at 0x3002.
`ifdef MISALIGN_TRAP_EN
      drive(1'b1, 1'b0, 2'b10, 1'b0, 64'h3002, 64'd0, 5'd16);
      push(64'd0, 5'd16, 1'b0, 1'b1, 1'b0);
      tick();
      idle_ex();
      chk("mis_no_req", {63'd0, dmem_req}, 64'd0);
      chk("mis_ex_ready", {63'd0, ex_ready}, 64'd1);
      tick();
      chk("mis_no_req_later", {63'd0, dmem_req}, 64'd0);
`else
      do_load(2'b10, 1'b0, 64'h3002, 64'h1122_3344_5566_7788, 5'd16, 0, 1, 64'h3000, 64'h5566_7788);
`endif

      // Reset while in WAIT, then a late rvalid.
      drive(1'b1, 1'b0, 2'b11, 1'b0, 64'h8000, 64'd0, 5'd17);
      tick();
      idle_ex();
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      tick();
      chk("rst_pre_ex_ready", {63'd0, ex_ready}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_async_ex_ready", {63'd0, ex_ready}, 64'd1);
      tick();
      check_reset_vals("midreset");
      rst = 1'b1;
      tick();
      dmem_rvalid = 1'b1;
      dmem_rdata = 64'hFFFF;
      tick();
      dmem_rvalid = 1'b0;
      chk("late_rvalid_wb", {63'd0, wb_valid}, 64'd0);
      chk("late_rvalid_wb_data", wb_data, 64'd0);
      chk("late_rvalid_ex_ready", {63'd0, ex_ready}, 64'd1);
      repeat (3) tick();

      chk("scoreboard_drain", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
